mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
// - Memory stage, directly downstream of the EX/MEM pipeline register. Takes its registered
//   control/data and drives a variable-latency data-memory handshake.
// - Stalls the upstream pipeline while an access is outstanding.
// - Registers the MEM/WB payload (writeback data, destination register, write enable, halt)
//   for the writeback stage.
// PARAMETERS
// - DATA_W    16  data/address width
// - REG_W     3   register-specifier width
// - MAX_WAIT  15  cycles without memDone before an access is declared failed
// - CNT_W     4   wait-counter width; must satisfy 2**CNT_W > MAX_WAIT
// PORTS
// - clk              in   1       clock
// - rst              in   1       reset, asynchronous, active-low
// - aluResIn         in   DATA_W  ALU result; memory address when MemRead/MemWrite
// - memWriteDataIn   in   DATA_W  store data
// - writeRegIn       in   REG_W   destination register
// - MemReadIn        in   1       load
// - MemWriteIn       in   1       store
// - MemToRegIn       in   1       writeback selects memory data
// - RegWriteIn       in   1       register write enable
// - HaltIn           in   1       halt instruction
// - memReq           out  1       memory request, level
// - memWr            out  1       1=write, 0=read; valid while memReq=1
// - memAddr          out  DATA_W  = aluResIn
// - memWdata         out  DATA_W  = memWriteDataIn
// - memRdata         in   DATA_W  read data; valid when memDone=1
// - memDone          in   1       access complete, 1-cycle pulse
// - stallMem         out  1       freezes PC, IF/ID, ID/EX and EX/MEM
// - wbDataOut        out  DATA_W  registered writeback data
// - writeRegOut      out  REG_W   registered destination register
// - RegWriteOut      out  1       registered write enable
// - HaltOut          out  1       registered halt
// - memErrOut        out  1       sticky error: misaligned address or timeout
// BEHAVIOUR
// - Reset (rst=0):
//   - All registered outputs are 0, FSM is IDLE, counter is 0.
//   - memReq and stallMem drop asynchronously.
// - op = MemReadIn | MemWriteIn.
// - misal = op & aluResIn[0]. A misaligned access never issues memReq. At the next edge:
//   - memErrOut=1 and HaltOut=1.
//   - RegWriteOut=0.
//   - No stall.
// - FSM states: IDLE, BUSY.
//   - IDLE with op & ~misal: memReq=1.
//     - If memDone=1 in the same cycle, the access completes and the FSM stays in IDLE.
//     - Otherwise the FSM goes to BUSY and the counter is cleared.
//   - BUSY: memReq=1 and the counter increments each cycle.
//     - memDone=1: complete, go to IDLE.
//     - Counter reaches MAX_WAIT with no memDone: timeout. memErrOut=1, HaltOut=1 and
//       RegWriteOut=0 at that edge, then go to IDLE.
//     - memDone wins over timeout when both happen in the same cycle.
// - Stall:
//   - stallMem = op & ~misal & ~memDone & ~timeout.
//   - stallMem is combinational, so it is low in the completion cycle.
//   - EX/MEM inputs are required to hold stable while stallMem=1.
// - MEM/WB register update, every edge:
//   - While stallMem=1: load a bubble, i.e. RegWriteOut=0, HaltOut=0, other fields don't-care.
//   - Otherwise: wbDataOut = MemToRegIn ? memRdata : aluResIn; writeRegOut = writeRegIn;
//     RegWriteOut = RegWriteIn; HaltOut = HaltIn.
// - Latency:
//   - Non-memory op: 1 cycle to the MEM/WB outputs.
//   - Memory op: N+1 cycles, where N is the number of cycles to memDone (0-wait gives 1).
// - Stores: MemToRegIn is don't-care and RegWriteIn is passed through as given.
// - memErrOut is sticky until reset.
//   - Once HaltOut=1, later memory ops still execute.
//   - Halting the pipeline is downstream's job.
// - memDone in IDLE with no op is ignored.
// - Reset asserted in BUSY aborts the access. The memory model must tolerate memReq
//   dropping without memDone.
// STRUCTURE
// - Shared package / header: FSM state encoding (IDLE=1'b0, BUSY=1'b1) and the DATA_W/REG_W
//   defaults.
// - Sub-module mem_req_fsm holds the FSM, the wait counter and the memReq/stallMem/timeout
//   logic.
// - The top level holds the writeback mux and the MEM/WB flops, built from async-reset flops.
// TESTING
// - ALU op: aluResIn=16'h1234, RegWriteIn=1, MemToRegIn=0
//   -> next edge wbDataOut=1234, RegWriteOut=1, stallMem never 1.
// - Load, memory done after 3 cycles: aluResIn=16'h0040, MemReadIn=1, memRdata=16'hBEEF
//   -> stallMem=1 for 3 cycles, wbDataOut=BEEF one edge after memDone, bubbles meanwhile.
// - 0-wait store: memDone=1 in the request cycle
//   -> memWr=1, memReq=1 for 1 cycle, stallMem=0, MEM/WB loads next edge.
// - Misaligned load: aluResIn=16'h0041
//   -> memReq=0, next edge memErrOut=1, HaltOut=1, RegWriteOut=0.
// - No memDone: MAX_WAIT=15
//   -> timeout after 15 BUSY cycles, memErrOut=1, FSM IDLE. Repeat with memDone arriving in
//   the timeout cycle -> normal completion, memErrOut=0.
// - rst pulled low mid-BUSY -> memReq, stallMem and all outputs 0 immediately; the next op
//   after release behaves normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM state encoding and default widths.
package mem_stage_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int REG_W_DEF  = 3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
endpackage

// File: rtl/mem_stage_if.sv
// Data-memory handshake between the memory stage (master) and the memory (slave).
interface mem_stage_if #(
    parameter int DATA_W = mem_stage_pkg::DATA_W_DEF
);
    logic              memReq;
    logic              memWr;
    logic [DATA_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;
    logic              memDone;

    modport master (
        output memReq, memWr, memAddr, memWdata,
        input  memRdata, memDone
    );

    modport slave (
        input  memReq, memWr, memAddr, memWdata,
        output memRdata, memDone
    );
endinterface

// File: rtl/mem_req_fsm.sv
// Request FSM: holds memReq until memDone, counts wait cycles and flags a timeout.
module mem_req_fsm
    import mem_stage_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic reqValid,
    input  logic memDone,
    output logic memReq,
    output logic stallMem,
    output logic timeout
);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    logic [0:0]       state;
    logic [0:0]       stateNxt;
    logic [CNT_W-1:0] waitCnt;
    logic             busy;

    assign busy = (state == BUSY);

    // The counter holds the number of completed BUSY cycles, so the MAX_WAIT-th
    // BUSY cycle is the one that sees LAST_WAIT. memDone in that cycle still wins.
    assign timeout  = busy & (waitCnt == LAST_WAIT) & ~memDone;
    assign memReq   = rst & (busy | reqValid);
    assign stallMem = rst & reqValid & ~memDone & ~timeout;

    always_comb begin
        stateNxt = state;
        if (!busy) begin
            if (reqValid && !memDone) stateNxt = BUSY;
        end else begin
            if (memDone || timeout) stateNxt = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            state <= stateNxt;
            if (busy) waitCnt <= waitCnt + 1'b1;
            else      waitCnt <= '0;
        end
    end
endmodule

// File: rtl/mem_stage.sv
// Memory stage: issues the data-memory access, stalls upstream while it is outstanding,
// and registers the MEM/WB payload.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int REG_W    = REG_W_DEF,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] aluResIn,
    input  logic [DATA_W-1:0] memWriteDataIn,
    input  logic [REG_W-1:0]  writeRegIn,
    input  logic              MemReadIn,
    input  logic              MemWriteIn,
    input  logic              MemToRegIn,
    input  logic              RegWriteIn,
    input  logic              HaltIn,
    mem_stage_if.master       mem,
    output logic              stallMem,
    output logic [DATA_W-1:0] wbDataOut,
    output logic [REG_W-1:0]  writeRegOut,
    output logic              RegWriteOut,
    output logic              HaltOut,
    output logic              memErrOut
);
    logic op;
    logic misal;
    logic reqValid;
    logic timeout;
    logic memFault;

    assign op       = MemReadIn | MemWriteIn;
    assign misal    = op & aluResIn[0];
    assign reqValid = op & ~misal;
    assign memFault = misal | timeout;

    assign mem.memWr    = MemWriteIn;
    assign mem.memAddr  = aluResIn;
    assign mem.memWdata = memWriteDataIn;

    mem_req_fsm #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) uFsm (
        .clk      (clk),
        .rst      (rst),
        .reqValid (reqValid),
        .memDone  (mem.memDone),
        .memReq   (mem.memReq),
        .stallMem (stallMem),
        .timeout  (timeout)
    );

    // A stall cycle loads a bubble; a faulted access retires as a halt with no write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbDataOut   <= '0;
            writeRegOut <= '0;
            RegWriteOut <= 1'b0;
            HaltOut     <= 1'b0;
            memErrOut   <= 1'b0;
        end else begin
            wbDataOut   <= MemToRegIn ? mem.memRdata : aluResIn;
            writeRegOut <= writeRegIn;
            RegWriteOut <= RegWriteIn & ~stallMem & ~memFault;
            HaltOut     <= ~stallMem & (HaltIn | memFault);
            if (memFault) memErrOut <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases plus random instructions against a per-instruction
// timing/result model (completion cycle = min(latency, MAX_WAIT)).
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int DW   = 16;
    localparam int RW   = 3;
    localparam int MAXW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] aluResIn = '0;
    logic [DW-1:0] memWriteDataIn = '0;
    logic [RW-1:0] writeRegIn = '0;
    logic          MemReadIn = 1'b0;
    logic          MemWriteIn = 1'b0;
    logic          MemToRegIn = 1'b0;
    logic          RegWriteIn = 1'b0;
    logic          HaltIn = 1'b0;
    logic          stallMem;
    logic [DW-1:0] wbDataOut;
    logic [RW-1:0] writeRegOut;
    logic          RegWriteOut;
    logic          HaltOut;
    logic          memErrOut;

    mem_stage_if #(.DATA_W(DW)) memBus ();

    mem_stage #(
        .DATA_W   (DW),
        .REG_W    (RW),
        .MAX_WAIT (MAXW),
        .CNT_W    (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .aluResIn       (aluResIn),
        .memWriteDataIn (memWriteDataIn),
        .writeRegIn     (writeRegIn),
        .MemReadIn      (MemReadIn),
        .MemWriteIn     (MemWriteIn),
        .MemToRegIn     (MemToRegIn),
        .RegWriteIn     (RegWriteIn),
        .HaltIn         (HaltIn),
        .mem            (memBus),
        .stallMem       (stallMem),
        .wbDataOut      (wbDataOut),
        .writeRegOut    (writeRegOut),
        .RegWriteOut    (RegWriteOut),
        .HaltOut        (HaltOut),
        .memErrOut      (memErrOut)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit modelErr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One instruction through the stage; lat = cycle (0 = request cycle) in which the
    // memory pulses memDone, anything above MAXW means it never answers.
    task automatic runOp(input logic [DW-1:0] a, input logic [DW-1:0] wd, input logic [RW-1:0] wreg,
                         input bit rdOp, input bit wrOp, input bit m2r, input bit rw, input bit halt,
                         input int lat, input logic [DW-1:0] rdat);
        bit isOp;
        bit mis;
        bit go;
        bit tout;
        bit fault;
        int c;
        isOp  = rdOp | wrOp;
        mis   = isOp & a[0];
        go    = isOp & ~mis;
        tout  = go && (lat > MAXW);
        c     = go ? (tout ? MAXW : lat) : 0;
        fault = mis | tout;
        for (int k = 0; k <= c; k++) begin
            @(negedge clk);
            if (k == 0) begin
                aluResIn = a; memWriteDataIn = wd; writeRegIn = wreg;
                MemReadIn = rdOp; MemWriteIn = wrOp; MemToRegIn = m2r;
                RegWriteIn = rw; HaltIn = halt;
            end
            if (go)        memBus.memDone = (k == lat);
            else if (isOp) memBus.memDone = 1'b0;
            else           memBus.memDone = 1'($urandom_range(0, 1));
            memBus.memRdata = (k == c) ? rdat : DW'($urandom);
            #1;
            chk("stallMem", stallMem, k < c);
            chk("memReq", memBus.memReq, go);
            if (go) begin
                chk("memWr", memBus.memWr, wrOp);
                chk("memAddr", memBus.memAddr, a);
                chk("memWdata", memBus.memWdata, wd);
            end
            @(posedge clk);
            #1;
            if (k < c) begin
                chk("bubbleRegWrite", RegWriteOut, 1'b0);
                chk("bubbleHalt", HaltOut, 1'b0);
            end
        end
        modelErr = modelErr | fault;
        chk("RegWriteOut", RegWriteOut, fault ? 1'b0 : rw);
        chk("HaltOut", HaltOut, fault ? 1'b1 : halt);
        chk("memErrOut", memErrOut, modelErr);
        if (!fault) begin
            chk("wbDataOut", wbDataOut, m2r ? rdat : a);
            chk("writeRegOut", writeRegOut, wreg);
        end
    endtask

    initial begin
        memBus.memDone  = 1'b0;
        memBus.memRdata = '0;
        #12;
        chk("rstMemReq", memBus.memReq, 1'b0);
        chk("rstStall", stallMem, 1'b0);
        chk("rstWbData", wbDataOut, 16'h0);
        chk("rstRegWrite", RegWriteOut, 1'b0);
        chk("rstHalt", HaltOut, 1'b0);
        chk("rstErr", memErrOut, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // ALU op, 3-wait load, 0-wait store, done exactly in the timeout cycle
        runOp(16'h1234, 16'h0000, 3'd2, 0, 0, 0, 1, 0, 0, 16'h5555);
        runOp(16'h0040, 16'h0000, 3'd5, 1, 0, 1, 1, 0, 3, 16'hBEEF);
        runOp(16'h0042, 16'hCAFE, 3'd1, 0, 1, 0, 0, 0, 0, 16'h0000);
        runOp(16'h0044, 16'h0000, 3'd3, 1, 0, 1, 1, 0, MAXW, 16'hA5A5);
        // misaligned load, then a load that never completes
        runOp(16'h0041, 16'h0000, 3'd4, 1, 0, 1, 1, 0, 0, 16'h1111);
        runOp(16'h0046, 16'h0000, 3'd6, 1, 0, 1, 1, 0, 99, 16'h2222);
        runOp(16'h0048, 16'h0000, 3'd7, 1, 0, 1, 1, 0, 1, 16'h3333);

        // reset in the middle of an outstanding load
        @(negedge clk);
        aluResIn = 16'h0080; MemReadIn = 1'b1; MemWriteIn = 1'b0; MemToRegIn = 1'b1;
        RegWriteIn = 1'b1; HaltIn = 1'b0; memBus.memDone = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("busyMemReq", memBus.memReq, 1'b1);
        chk("busyStall", stallMem, 1'b1);
        rst = 1'b0;
        #1;
        chk("abortMemReq", memBus.memReq, 1'b0);
        chk("abortStall", stallMem, 1'b0);
        chk("abortErr", memErrOut, 1'b0);
        chk("abortRegWrite", RegWriteOut, 1'b0);
        chk("abortWbData", wbDataOut, 16'h0);
        modelErr = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        MemReadIn = 1'b0;
        runOp(16'h0050, 16'h0000, 3'd3, 1, 0, 1, 1, 0, 2, 16'h7777);

        for (int i = 0; i < 60; i++) begin
            int t;
            int r;
            int lat;
            logic [DW-1:0] a;
            t = $urandom_range(0, 2);
            r = $urandom_range(0, 15);
            lat = (r < 12) ? (r % 5) : (r == 12) ? MAXW : (r == 13) ? MAXW - 1 : 20;
            a = DW'($urandom) & 16'hFFFE;
            if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
            runOp(a, DW'($urandom), RW'($urandom), t == 1, t == 2, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, lat, DW'($urandom));
        end

        memBus.memDone = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
